// File: rtl/riscv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pipe_pkg
// Description : Shared pipeline types, forwarding-mux encodings and helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pipe_pkg;

    localparam int REGW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_ALU = 2'b10;

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rd;
        logic            regwrite;
        logic            memread;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
    } stage_tag_t;

    // True when this stage will write register r; x0 is never a producer.
    function automatic logic dst_matches(input stage_tag_t t, input logic [REGW-1:0] r);
        return t.valid && t.regwrite && (t.rd != '0) && (t.rd == r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stage_tag_reg.sv
`default_nettype none
// ============================================================================
// Module      : stage_tag_reg
// Description : One pipeline tag stage with load and bubble (valid clear).
// Revision    : 1.0 - initial release
// ============================================================================
module stage_tag_reg
    import riscv_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_bubble,
    input  stage_tag_t i_tag,
    output stage_tag_t o_tag
);

    stage_tag_t r_tag;

    // A bubble only kills valid; the stale payload is gated by valid downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else if (i_bubble) begin
            r_tag.valid <= 1'b0;
        end else if (i_load) begin
            r_tag <= i_tag;
        end
    end

    assign o_tag = r_tag;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Operand forwarding select, load-use stall and branch flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            ex_branch_taken,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic            stall,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [CNTW-1:0] stall_count
);

    import riscv_pipe_pkg::*;

    stage_tag_t      w_id_tag;
    stage_tag_t      w_ex;
    stage_tag_t      w_mem;
    stage_tag_t      w_wb;
    logic            w_flush;
    logic            w_hazard;
    logic            w_stall;
    logic            w_ex_bubble;
    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [CNTW-1:0] r_stall_count;
    logic            w_unused_tag_bits;

    always_comb begin
        w_id_tag          = '0;
        w_id_tag.valid    = id_valid;
        w_id_tag.rd       = id_rd;
        w_id_tag.regwrite = id_regwrite;
        w_id_tag.memread  = id_memread;
        w_id_tag.rs1      = id_rs1;
        w_id_tag.rs2      = id_rs2;
        w_id_tag.use_rs1  = id_use_rs1;
        w_id_tag.use_rs2  = id_use_rs2;
    end

    assign w_ex_bubble = w_stall | w_flush;

    stage_tag_reg u_ex_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (w_ex_bubble),
        .i_tag    (w_id_tag),
        .o_tag    (w_ex)
    );

    stage_tag_reg u_mem_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_tag    (w_ex),
        .o_tag    (w_mem)
    );

    stage_tag_reg u_wb_tag (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (1'b1),
        .i_bubble (1'b0),
        .i_tag    (w_mem),
        .o_tag    (w_wb)
    );

    // MEM is the younger producer, so it is tested before WB.
    always_comb begin
        w_fwd_a = FWD_REG;
        w_fwd_b = FWD_REG;
        if (w_ex.valid && w_ex.use_rs1) begin
            if (dst_matches(w_mem, w_ex.rs1)) begin
                w_fwd_a = FWD_ALU;
            end else if (dst_matches(w_wb, w_ex.rs1)) begin
                w_fwd_a = FWD_WB;
            end
        end
        if (w_ex.valid && w_ex.use_rs2) begin
            if (dst_matches(w_mem, w_ex.rs2)) begin
                w_fwd_b = FWD_ALU;
            end else if (dst_matches(w_wb, w_ex.rs2)) begin
                w_fwd_b = FWD_WB;
            end
        end
    end

    assign w_flush  = ex_branch_taken & w_ex.valid;
    assign w_hazard = id_valid & w_ex.valid & w_ex.memread & (w_ex.rd != '0)
                    & ((id_use_rs1 & (id_rs1 == w_ex.rd))
                     | (id_use_rs2 & (id_rs2 == w_ex.rd)));
    // A taken branch squashes the dependent anyway, so it overrides the stall.
    assign w_stall  = w_hazard & ~w_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != {CNTW{1'b1}})) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign fwd_a_sel   = w_fwd_a;
    assign fwd_b_sel   = w_fwd_b;
    assign stall       = w_stall;
    assign flush_ifid  = w_flush;
    assign flush_idex  = w_flush;
    assign stall_count = r_stall_count;

    // Source-operand and load fields are only meaningful in EX.
    assign w_unused_tag_bits = ^{w_mem.memread, w_mem.rs1, w_mem.rs2, w_mem.use_rs1, w_mem.use_rs2,
                                 w_wb.memread,  w_wb.rs1,  w_wb.rs2,  w_wb.use_rs1,  w_wb.use_rs2};

endmodule
`default_nettype wire
